// File: rtl/mmc1_mapper_ctrl.sv
// MMC1-style serial-load bank controller: turns CPU writes at $8000-$FFFF into
// five-bit serial register loads and produces banked PRG/CHR addresses and mirroring.
module mmc1_mapper_ctrl #(
  parameter int PRG_AW = 18,
  parameter int CHR_AW = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              prg_nce_in,
  input  logic [14:0]       prg_a_in,
  input  logic              prg_r_nw_in,
  input  logic [7:0]        prg_d_in,
  input  logic [13:0]       chr_a_in,
  output logic [PRG_AW-1:0] prg_rom_a_out,
  output logic [CHR_AW-1:0] chr_rom_a_out,
  output logic              ciram_nce_out,
  output logic              ciram_a10_out,
  output logic              wram_en_out
);

  logic       wr_act;
  logic       wr_q;
  logic       strobe;
  logic [4:0] shift_r;
  logic [4:0] ctrl_r;
  logic [4:0] chr0_r;
  logic [4:0] chr1_r;
  logic [4:0] prg_r;
  logic [4:0] load_val;

  // Edge-detect the write so a slow bus cycle spanning many clocks loads once.
  assign wr_act   = ~prg_nce_in & ~prg_r_nw_in;
  assign strobe   = wr_act & ~wr_q;
  assign load_val = {prg_d_in[0], shift_r[4:1]};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_q    <= 1'b0;
      shift_r <= 5'b10000;
      ctrl_r  <= 5'h0C;
      chr0_r  <= 5'h00;
      chr1_r  <= 5'h00;
      prg_r   <= 5'h00;
    end else begin
      wr_q <= wr_act;
      if (strobe) begin
        if (prg_d_in[7]) begin
          shift_r <= 5'b10000;
          ctrl_r  <= ctrl_r | 5'h0C;
        end else if (!shift_r[0]) begin
          shift_r <= load_val;
        end else begin
          // Sentinel reached bit 0: this is the fifth bit, commit and restart.
          shift_r <= 5'b10000;
          case (prg_a_in[14:13])
            2'd0:    ctrl_r <= load_val;
            2'd1:    chr0_r <= load_val;
            2'd2:    chr1_r <= load_val;
            default: prg_r  <= load_val;
          endcase
        end
      end
    end
  end

  logic [3:0]  prg_bank;
  logic [17:0] prg_addr;
  logic [16:0] chr_addr;
  logic        a10;

  always_comb begin
    prg_bank = prg_r[3:0];
    prg_addr = {prg_r[3:1], prg_a_in};
    case (ctrl_r[3:2])
      2'd2: begin
        prg_bank = prg_a_in[14] ? prg_r[3:0] : 4'h0;
        prg_addr = {prg_bank, prg_a_in[13:0]};
      end
      2'd3: begin
        prg_bank = prg_a_in[14] ? 4'hF : prg_r[3:0];
        prg_addr = {prg_bank, prg_a_in[13:0]};
      end
      default: ;
    endcase
  end

  always_comb begin
    chr_addr = {chr0_r[4:1], chr_a_in[12:0]};
    if (ctrl_r[4])
      chr_addr = {(chr_a_in[12] ? chr1_r : chr0_r), chr_a_in[11:0]};
  end

  always_comb begin
    a10 = 1'b0;
    case (ctrl_r[1:0])
      2'd0: a10 = 1'b0;
      2'd1: a10 = 1'b1;
      2'd2: a10 = chr_a_in[10];
      2'd3: a10 = chr_a_in[11];
      default: ;
    endcase
  end

  assign prg_rom_a_out = prg_addr;
  assign chr_rom_a_out = chr_addr;
  assign ciram_a10_out = a10;
  assign ciram_nce_out = ~chr_a_in[13];
  assign wram_en_out   = ~prg_r[4];

endmodule

// File: tb/tb_mmc1_mapper_ctrl.sv
// Scoreboard bench for mmc1_mapper_ctrl: directed bus cycles push expected
// output snapshots; a monitor pops and compares them when a sample is presented.
module tb_mmc1_mapper_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        prg_nce_in = 1'b1;
  logic [14:0] prg_a_in = '0;
  logic        prg_r_nw_in = 1'b1;
  logic [7:0]  prg_d_in = '0;
  logic [13:0] chr_a_in = '0;
  logic [17:0] prg_rom_a_out;
  logic [16:0] chr_rom_a_out;
  logic        ciram_nce_out;
  logic        ciram_a10_out;
  logic        wram_en_out;

  typedef struct packed {
    logic [17:0] prg;
    logic [16:0] chr;
    logic        nce;
    logic        a10;
    logic        wram;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  logic  sample_req = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;

  mmc1_mapper_ctrl #(.PRG_AW(18), .CHR_AW(17)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .prg_nce_in    (prg_nce_in),
    .prg_a_in      (prg_a_in),
    .prg_r_nw_in   (prg_r_nw_in),
    .prg_d_in      (prg_d_in),
    .chr_a_in      (chr_a_in),
    .prg_rom_a_out (prg_rom_a_out),
    .chr_rom_a_out (chr_rom_a_out),
    .ciram_nce_out (ciram_nce_out),
    .ciram_a10_out (ciram_a10_out),
    .wram_en_out   (wram_en_out)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: samples 1 ns after the rising edge whenever a snapshot is presented.
  always @(posedge clk_in) begin
    if (sample_req) begin
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL monitor_underflow: sample presented with empty scoreboard");
      end else begin
        snap_t e;
        snap_t a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{prg: prg_rom_a_out, chr: chr_rom_a_out, nce: ciram_nce_out,
               a10: ciram_a10_out, wram: wram_en_out};
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got prg=%05h chr=%05h nce=%b a10=%b wram=%b, want prg=%05h chr=%05h nce=%b a10=%b wram=%b",
                   nm, a.prg, a.chr, a.nce, a.a10, a.wram, e.prg, e.chr, e.nce, e.a10, e.wram);
        end
      end
    end
  end

  task automatic write_byte(input logic [15:0] addr, input logic [7:0] d, input int hold);
    @(negedge clk_in);
    prg_nce_in  = ~addr[15];
    prg_a_in    = addr[14:0];
    prg_d_in    = d;
    prg_r_nw_in = 1'b0;
    repeat (hold) @(negedge clk_in);
    prg_r_nw_in = 1'b1;
    prg_nce_in  = 1'b1;
  endtask

  task automatic serial_load(input logic [15:0] addr, input logic [4:0] val);
    for (int i = 0; i < 5; i++) write_byte(addr, {7'b0, val[i]}, 1);
  endtask

  task automatic check(input string nm, input logic [15:0] cpu, input logic [15:0] ppu,
                       input logic [17:0] e_prg, input logic [16:0] e_chr,
                       input logic e_nce, input logic e_a10, input logic e_wram);
    snap_t e;
    @(negedge clk_in);
    prg_nce_in  = ~cpu[15];
    prg_a_in    = cpu[14:0];
    prg_r_nw_in = 1'b1;
    chr_a_in    = ppu[13:0];
    e = '{prg: e_prg, chr: e_chr, nce: e_nce, a10: e_a10, wram: e_wram};
    exp_q.push_back(e);
    name_q.push_back(nm);
    sample_req = 1'b1;
    @(negedge clk_in);
    sample_req = 1'b0;
    prg_nce_in = 1'b1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    #2;
    rst_in = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;

    check("reset_state", 16'hC123, 16'h2C00, 18'h3C123, 17'h00C00, 1'b0, 1'b0, 1'b1);

    serial_load(16'h8000, 5'h0E);
    check("vert_2400", 16'hC123, 16'h2400, 18'h3C123, 17'h00400, 1'b0, 1'b1, 1'b1);
    check("vert_2800", 16'hC123, 16'h2800, 18'h3C123, 17'h00800, 1'b0, 1'b0, 1'b1);
    serial_load(16'h8000, 5'h0F);
    check("horiz_2400", 16'hC123, 16'h2400, 18'h3C123, 17'h00400, 1'b0, 1'b0, 1'b1);
    check("horiz_2800", 16'hC123, 16'h2800, 18'h3C123, 17'h00800, 1'b0, 1'b1, 1'b1);

    serial_load(16'hE000, 5'h05);
    check("prg_8010", 16'h8010, 16'h0000, 18'h14010, 17'h00000, 1'b1, 1'b0, 1'b1);
    check("prg_c000_fixed", 16'hC000, 16'h0000, 18'h3C000, 17'h00000, 1'b1, 1'b0, 1'b1);
    serial_load(16'hE000, 5'h15);
    check("wram_off", 16'h8010, 16'h0000, 18'h14010, 17'h00000, 1'b1, 1'b0, 1'b0);

    serial_load(16'h8000, 5'h10);
    serial_load(16'hA000, 5'h03);
    serial_load(16'hC000, 5'h1F);
    check("chr4k_lo", 16'hC123, 16'h0005, 18'h14123, 17'h03005, 1'b1, 1'b0, 1'b0);
    check("chr4k_hi", 16'hC123, 16'h1FFF, 18'h14123, 17'h1FFFF, 1'b1, 1'b0, 1'b0);

    // Partial shift abandoned by a reset write.
    for (int i = 0; i < 3; i++) write_byte(16'h8000, 8'h01, 1);
    write_byte(16'h8000, 8'h80, 1);
    check("reset_write_ctrl", 16'h8010, 16'h2405, 18'h14010, 17'h03405, 1'b0, 1'b0, 1'b0);
    serial_load(16'h8000, 5'h12);
    check("clean_after_80", 16'hC123, 16'h2400, 18'h14123, 17'h03400, 1'b0, 1'b1, 1'b0);

    // Partial shift abandoned by rst_in.
    write_byte(16'h8000, 8'h01, 1);
    write_byte(16'h8000, 8'h01, 1);
    pulse_reset();
    check("rst_mid_seq", 16'hC123, 16'h1005, 18'h3C123, 17'h01005, 1'b1, 1'b0, 1'b1);
    serial_load(16'h8000, 5'h0E);
    check("clean_after_rst", 16'hC123, 16'h2400, 18'h3C123, 17'h00400, 1'b0, 1'b1, 1'b1);

    // A write held four clocks contributes one bit only.
    pulse_reset();
    write_byte(16'h8000, 8'h01, 4);
    check("held_no_load", 16'hC123, 16'h2000, 18'h3C123, 17'h00000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) write_byte(16'h8000, 8'h00, 1);
    check("held_one_bit", 16'hC123, 16'h2000, 18'h04123, 17'h00000, 1'b0, 1'b1, 1'b1);

    // Reads and deselected writes interleaved with a serial load do not shift.
    pulse_reset();
    write_byte(16'h8000, 8'h00, 1);
    write_byte(16'h8000, 8'h01, 1);
    check("read_between", 16'hC123, 16'h2400, 18'h3C123, 17'h00400, 1'b0, 1'b0, 1'b1);
    write_byte(16'h0000, 8'h01, 2);
    check("nce_high_write", 16'h8000, 16'h2400, 18'h00000, 17'h00400, 1'b0, 1'b0, 1'b1);
    write_byte(16'h8000, 8'h01, 1);
    write_byte(16'h8000, 8'h01, 1);
    write_byte(16'h8000, 8'h00, 1);
    check("interleaved_load", 16'hC123, 16'h2400, 18'h3C123, 17'h00400, 1'b0, 1'b1, 1'b1);
    check("interleaved_2800", 16'hC123, 16'h2800, 18'h3C123, 17'h00800, 1'b0, 1'b0, 1'b1);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
        @(negedge clk_in);
        budget++;
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: %0d snapshots left, want 0", exp_q.size());
      end
    end
    repeat (2) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmc1_mapper_ctrl.md
Name: mmc1_mapper_ctrl

Overview:
- Serial-load bank controller (MMC1-style) between CPU PRG bus and the cart PRG/CHR ROMs.
- Decodes CPU writes to $8000-$FFFF into five-bit serial writes to four internal registers: control, CHR bank 0, CHR bank 1 and PRG bank.
- Drives banked PRG/CHR ROM addresses, nametable mirroring (CIRAM A10/nCE) and WRAM enable, so larger PRG/CHR images fit behind the existing ROM blocks.

Parameters:
- PRG_AW, 18, PRG ROM address width (256 KB, 16 banks of 16 KB); bank bits fixed at 4.
- CHR_AW, 17, CHR ROM address width (128 KB, 32 banks of 4 KB); bank bits fixed at 5.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous reset, active-high
- prg_nce_in  input  1  PRG chip enable, active low ($8000-$FFFF)
- prg_a_in  input  15  CPU address A14..A0
- prg_r_nw_in  input  1  CPU read/write (0 = write)
- prg_d_in  input  8  CPU write data
- chr_a_in  input  14  PPU address A13..A0
- prg_rom_a_out  output  PRG_AW  banked PRG ROM address
- chr_rom_a_out  output  CHR_AW  banked CHR ROM address
- ciram_nce_out  output  1  VRAM chip enable, active low
- ciram_a10_out  output  1  VRAM A10 (mirroring)
- wram_en_out  output  1  $6000 WRAM enable, active high

Behaviour:
- Write strobe:
  - wr_act = ~prg_nce_in & ~prg_r_nw_in; wr_q = wr_act registered.
  - strobe = wr_act & ~wr_q: exactly one strobe per write bus cycle, however many clk cycles it lasts.
  - prg_d_in and prg_a_in[14:13] are sampled in the strobe cycle.
- Shift register: 5 bits, sentinel-based, reset value 5'b10000.
  - On strobe with d[7]=1: shift <= 10000; control <= control | 5'h0C; other registers unchanged.
  - On strobe with d[7]=0 and shift[0]=0: shift <= {d[0], shift[4:1]} (LSB first).
  - On strobe with d[7]=0 and shift[0]=1 (fifth write): value = {d[0], shift[4:1]} goes to the register selected by a[14:13]; shift <= 10000.
  - Register select: 0 = control, 1 = chr0, 2 = chr1, 3 = prg.
- Register reset values: control = 5'h0C, chr0 = 0, chr1 = 0, prg = 0.
  - All state clears asynchronously on rst_in, including mid-sequence partial shifts.
- Latency: a register load at the strobe-cycle clock edge is visible on all outputs from the next cycle. Outputs are combinational from registers and the current address buses.
- Mirroring (control[1:0]):
  - 0: ciram_a10_out = 0
  - 1: ciram_a10_out = 1
  - 2 (vertical): ciram_a10_out = chr_a_in[10]
  - 3 (horizontal): ciram_a10_out = chr_a_in[11]
- ciram_nce_out = ~chr_a_in[13].
- PRG mode (control[3:2]):
  - 0/1: 32 KB mode, prg_rom_a_out = {prg[3:1], prg_a_in[14:0]}.
  - 2: $8000 fixed to bank 0, $C000 = prg[3:0].
  - 3: $8000 = prg[3:0], $C000 fixed to bank 4'hF.
  - In 16 KB modes: prg_rom_a_out = {bank, prg_a_in[13:0]}.
- CHR mode (control[4]):
  - 0: chr_rom_a_out = {chr0[4:1], chr_a_in[12:0]}.
  - 1: chr_rom_a_out = {chr_a_in[12] ? chr1 : chr0, chr_a_in[11:0]}.
- wram_en_out = ~prg[4].
- Reads (prg_r_nw_in = 1) and accesses with prg_nce_in = 1 never strobe.
- A write held across many cycles loads once. Back-to-back writes need wr_act low for at least one clk between them.

Test Plan:
- Reset, then PPU $2C00 and CPU $C123 read → ciram_a10_out=0, ciram_nce_out=0, prg_rom_a_out=18'h3C123, wram_en_out=1.
- Five writes to $8000 with d[0] = 0,1,1,1,0 (control = 0x0E) → PPU $2400 gives ciram_a10_out=1, PPU $2800 gives 0. Repeat with 0x0F → $2400 gives 0, $2800 gives 1.
- Five writes to $E000 loading 0x05, then CPU read $8010 → prg_rom_a_out=18'h14010; CPU $C000 → 18'h3C000. Load prg = 0x15 → wram_en_out=0.
- Load control = 0x10 (4 KB CHR), chr0 = 0x03 ($A000), chr1 = 0x1F ($C000) → PPU $0005 gives chr_rom_a_out=17'h03005, PPU $1FFF gives 17'h1FFFF.
- Three serial writes, then a write of 0x80 → shift clears, control reads 0x0C|old; next five writes load cleanly. Same with rst_in pulse mid-sequence → all registers at reset values.
- Single write held for 4 clks with d[0]=1 → shift advances by exactly one bit. Read cycles with prg_r_nw_in=1 → no shift change.
